// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared types and constants for the mem_responder slice:
//               FSM state encoding, latched-request record, word geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

  // Bytes per storage word; the word index is the byte offset divided by this.
  localparam int MEM_WORD_BYTES = 8;

  // Responder sequencing states, explicitly encoded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_resp_state_e;

  // Request captured at the handshake; is_data selects the granted port.
  typedef struct packed {
    logic        is_data;
    logic [63:0] addr;
    logic        we;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
  } mem_req_s;

endpackage
`default_nettype wire

// File: rtl/mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_ram
// Description : Single-port synchronous word store, 64-bit read, byte-strobed
//               write. Read data is registered and holds while en is low.
//               Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wstrb,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] r_mem [DEPTH];
  logic [63:0] r_rdata;

  // One access per enabled cycle: strobed byte write plus registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < MEM_WORD_BYTES; b++) begin
        if (we && wstrb[b]) begin
          r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      r_rdata <= r_mem[idx];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Two-port (fetch / data) memory responder with one outstanding
//               request, fixed data-over-fetch priority and a configurable
//               request-to-response latency.
//               Optional feature macro: MEM_RESPONDER_ACCESS_FAULT_EN
//               (defined: out-of-range accesses fault; undefined: index wraps).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_resp_valid,
  input  logic        if_resp_ready,
  output logic [31:0] if_resp_inst,
  output logic        if_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [63:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [7:0]  d_req_wstrb,
  input  logic [63:0] d_req_wdata,
  output logic        d_resp_valid,
  input  logic        d_resp_ready,
  output logic [63:0] d_resp_rdata,
  output logic        d_resp_err
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int          C_OFF_W = $clog2(MEM_WORD_BYTES);
  localparam logic [63:0] C_SPAN  = 64'(DEPTH) * 64'(MEM_WORD_BYTES);

  mem_resp_state_e  r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  mem_req_s         r_req, w_in, w_acc;
  logic             w_d_hs, w_if_hs, w_hs, w_resp_hs;
  logic             w_acc_go, w_ram_we, w_resp_err;
  logic [IDX_W-1:0] w_acc_idx;
  logic [63:0]      w_rdata;

  // Fault rule: misaligned fetches always fault; range faults only when enabled.
  function automatic logic acc_err(input mem_req_s req);
    logic err;
    err = !req.is_data && (req.addr[1:0] != 2'b00);
`ifdef MEM_RESPONDER_ACCESS_FAULT_EN
    if ((req.addr < BASE_ADDR) || ((req.addr - BASE_ADDR) >= C_SPAN)) begin
      err = 1'b1;
    end
`endif
    return err;
  endfunction

  // Word index; the low address bits are dropped and the index wraps mod DEPTH.
  function automatic logic [IDX_W-1:0] acc_idx(input mem_req_s req);
    return IDX_W'((req.addr - BASE_ADDR) >> C_OFF_W) & IDX_W'(DEPTH - 1);
  endfunction

  // Incoming request as seen by the arbiter: data port wins when both are valid.
  always_comb begin
    w_in.is_data = d_req_valid;
    w_in.addr    = d_req_valid ? d_req_addr : if_req_addr;
    w_in.we      = d_req_valid & d_req_we;
    w_in.wstrb   = d_req_valid ? d_req_wstrb : 8'h00;
    w_in.wdata   = d_req_valid ? d_req_wdata : 64'h0;
  end

  assign w_d_hs  = (r_state == IDLE) && d_req_valid;
  assign w_if_hs = (r_state == IDLE) && if_req_valid && !d_req_valid;
  assign w_hs    = w_d_hs || w_if_hs;

  assign w_resp_hs = (r_state == RESP) &&
                     (r_req.is_data ? d_resp_ready : if_resp_ready);

  // With LATENCY=1 the storage access coincides with the handshake edge, so the
  // live request feeds the RAM; otherwise the latched copy does.
  assign w_acc     = (r_state == IDLE) ? w_in : r_req;
  assign w_acc_go  = (LATENCY == 1) ? w_hs
                                    : ((r_state == BUSY) && (r_cnt == CNT_W'(1)));
  assign w_acc_idx = acc_idx(w_acc);
  assign w_ram_we  = w_acc_go && w_acc.we && !acc_err(w_acc);

  assign w_resp_err = acc_err(r_req);

  mem_responder_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (w_acc_go),
    .we    (w_ram_we),
    .idx   (w_acc_idx),
    .wstrb (w_acc.wstrb),
    .wdata (w_acc.wdata),
    .rdata (w_rdata)
  );

  // Capture the granted request so the response stays stable until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req <= '0;
    end else if (w_hs) begin
      r_req <= w_in;
    end
  end

  // State and latency countdown registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: BUSY is held for LATENCY-1 cycles by the countdown.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          if (LATENCY > 1) begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CNT_W'(LATENCY - 1);
          end else begin
            w_state_nxt = RESP;
          end
        end
      end
      BUSY: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RESP: begin
        if (w_resp_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: readies only in IDLE, response only toward the granted port.
  always_comb begin
    d_req_ready   = 1'b0;
    if_req_ready  = 1'b0;
    d_resp_valid  = 1'b0;
    d_resp_rdata  = 64'h0;
    d_resp_err    = 1'b0;
    if_resp_valid = 1'b0;
    if_resp_inst  = 32'h0;
    if_resp_err   = 1'b0;
    case (r_state)
      IDLE: begin
        d_req_ready  = d_req_valid;
        if_req_ready = if_req_valid && !d_req_valid;
      end
      RESP: begin
        if (r_req.is_data) begin
          d_resp_valid = 1'b1;
          d_resp_err   = w_resp_err;
          d_resp_rdata = (w_resp_err || r_req.we) ? 64'h0 : w_rdata;
        end else begin
          if_resp_valid = 1'b1;
          if_resp_err   = w_resp_err;
          if_resp_inst  = w_resp_err ? 32'h0
                        : (r_req.addr[2] ? w_rdata[63:32] : w_rdata[31:0]);
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench. Instance 0 runs with LATENCY=1,
//               instance 1 with LATENCY=3; both use a 16-word store.
//               Expected out-of-range behaviour follows
//               MEM_RESPONDER_ACCESS_FAULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int          DEPTH = 16;
  localparam logic [63:0] BASE  = 64'h8000_0000;
`ifdef MEM_RESPONDER_ACCESS_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req_valid [2];
  logic        if_req_ready [2];
  logic [63:0] if_req_addr  [2];
  logic        if_resp_valid[2];
  logic        if_resp_ready[2];
  logic [31:0] if_resp_inst [2];
  logic        if_resp_err  [2];
  logic        d_req_valid  [2];
  logic        d_req_ready  [2];
  logic [63:0] d_req_addr   [2];
  logic        d_req_we     [2];
  logic [7:0]  d_req_wstrb  [2];
  logic [63:0] d_req_wdata  [2];
  logic        d_resp_valid [2];
  logic        d_resp_ready [2];
  logic [63:0] d_resp_rdata [2];
  logic        d_resp_err   [2];

  int n_tests = 0;
  int n_fail  = 0;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid[0]), .if_req_ready(if_req_ready[0]), .if_req_addr(if_req_addr[0]),
    .if_resp_valid(if_resp_valid[0]), .if_resp_ready(if_resp_ready[0]),
    .if_resp_inst(if_resp_inst[0]), .if_resp_err(if_resp_err[0]),
    .d_req_valid(d_req_valid[0]), .d_req_ready(d_req_ready[0]), .d_req_addr(d_req_addr[0]),
    .d_req_we(d_req_we[0]), .d_req_wstrb(d_req_wstrb[0]), .d_req_wdata(d_req_wdata[0]),
    .d_resp_valid(d_resp_valid[0]), .d_resp_ready(d_resp_ready[0]),
    .d_resp_rdata(d_resp_rdata[0]), .d_resp_err(d_resp_err[0])
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(3), .BASE_ADDR(BASE)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid[1]), .if_req_ready(if_req_ready[1]), .if_req_addr(if_req_addr[1]),
    .if_resp_valid(if_resp_valid[1]), .if_resp_ready(if_resp_ready[1]),
    .if_resp_inst(if_resp_inst[1]), .if_resp_err(if_resp_err[1]),
    .d_req_valid(d_req_valid[1]), .d_req_ready(d_req_ready[1]), .d_req_addr(d_req_addr[1]),
    .d_req_we(d_req_we[1]), .d_req_wstrb(d_req_wstrb[1]), .d_req_wdata(d_req_wdata[1]),
    .d_resp_valid(d_resp_valid[1]), .d_resp_ready(d_resp_ready[1]),
    .d_resp_rdata(d_resp_rdata[1]), .d_resp_err(d_resp_err[1])
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Full data transaction on instance u with latency and response checks.
  task automatic d_access(input int u, input logic [63:0] addr, input logic we,
                          input logic [7:0] strb, input logic [63:0] wdata,
                          input logic [63:0] exp_data, input logic exp_err, input string tag);
    int cyc;
    @(negedge clk);
    d_req_valid[u] = 1'b1; d_req_addr[u] = addr; d_req_we[u] = we;
    d_req_wstrb[u] = strb; d_req_wdata[u] = wdata;
    #1 check({tag, " d_req_ready"}, 64'(d_req_ready[u]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    d_req_valid[u] = 1'b0; d_resp_ready[u] = 1'b1;
    cyc = 1;
    while (!d_resp_valid[u] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), (u == 0) ? 64'd1 : 64'd3);
    check({tag, " rdata"}, d_resp_rdata[u], exp_data);
    check({tag, " err"}, 64'(d_resp_err[u]), 64'(exp_err));
    @(posedge clk);
    @(negedge clk);
    d_resp_ready[u] = 1'b0;
    #1 check({tag, " resp_valid drop"}, 64'(d_resp_valid[u]), 64'd0);
  endtask

  // Full fetch transaction on instance u.
  task automatic f_access(input int u, input logic [63:0] addr,
                          input logic [31:0] exp_inst, input logic exp_err, input string tag);
    int cyc;
    @(negedge clk);
    if_req_valid[u] = 1'b1; if_req_addr[u] = addr;
    #1 check({tag, " if_req_ready"}, 64'(if_req_ready[u]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    if_req_valid[u] = 1'b0; if_resp_ready[u] = 1'b1;
    cyc = 1;
    while (!if_resp_valid[u] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), (u == 0) ? 64'd1 : 64'd3);
    check({tag, " inst"}, 64'(if_resp_inst[u]), 64'(exp_inst));
    check({tag, " err"}, 64'(if_resp_err[u]), 64'(exp_err));
    @(posedge clk);
    @(negedge clk);
    if_resp_ready[u] = 1'b0;
  endtask

  // Absolute time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int cyc;
    for (int u = 0; u < 2; u++) begin
      if_req_valid[u] = 1'b0; if_req_addr[u] = '0; if_resp_ready[u] = 1'b0;
      d_req_valid[u] = 1'b0; d_req_addr[u] = '0; d_req_we[u] = 1'b0;
      d_req_wstrb[u] = '0; d_req_wdata[u] = '0; d_resp_ready[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst d_resp_valid", 64'(d_resp_valid[u]), 64'd0);
      check("rst if_resp_valid", 64'(if_resp_valid[u]), 64'd0);
      check("rst d_resp_rdata", d_resp_rdata[u], 64'd0);
      check("rst if_resp_inst", 64'(if_resp_inst[u]), 64'd0);
      check("rst errs", 64'({d_resp_err[u], if_resp_err[u]}), 64'd0);
    end
    rst = 1'b0;

    // Store then load, byte-offset bits ignored on data accesses.
    d_access(0, BASE + 64'h10, 1'b1, 8'hFF, 64'h1122334455667788, 64'h0, 1'b0, "st_w2");
    d_access(0, BASE + 64'h10, 1'b0, 8'h00, 64'h0, 64'h1122334455667788, 1'b0, "ld_w2");
    d_access(0, BASE + 64'h13, 1'b0, 8'h00, 64'h0, 64'h1122334455667788, 1'b0, "ld_w2_low");

    // Strobed write over a cleared word.
    d_access(0, BASE, 1'b1, 8'hFF, 64'h0, 64'h0, 1'b0, "clr_w0");
    d_access(0, BASE, 1'b1, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, "strb_w0");
    d_access(0, BASE, 1'b0, 8'h00, 64'h0, 64'h0000_0000_FFFF_FFFF, 1'b0, "ld_strb");

    // Arbitration: data store and fetch of upper half offered together.
    @(negedge clk);
    d_req_valid[0] = 1'b1; d_req_addr[0] = BASE; d_req_we[0] = 1'b1;
    d_req_wstrb[0] = 8'hFF; d_req_wdata[0] = 64'hDEAD_BEEF_CAFE_F00D;
    if_req_valid[0] = 1'b1; if_req_addr[0] = BASE + 64'h4;
    #1;
    check("arb d_req_ready", 64'(d_req_ready[0]), 64'd1);
    check("arb if_req_ready", 64'(if_req_ready[0]), 64'd0);
    @(posedge clk);
    @(negedge clk);
    d_req_valid[0] = 1'b0; d_resp_ready[0] = 1'b1;
    #1;
    check("arb d_resp_valid", 64'(d_resp_valid[0]), 64'd1);
    check("arb if_resp_valid idle", 64'(if_resp_valid[0]), 64'd0);
    check("arb if_req_ready in resp", 64'(if_req_ready[0]), 64'd0);
    @(posedge clk);
    @(negedge clk);
    d_resp_ready[0] = 1'b0;
    #1 check("arb if_req_ready after", 64'(if_req_ready[0]), 64'd1);
    if_resp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if_req_valid[0] = 1'b0;
    #1;
    check("arb if_resp_valid", 64'(if_resp_valid[0]), 64'd1);
    check("arb inst upper", 64'(if_resp_inst[0]), 64'hDEAD_BEEF);
    check("arb err", 64'(if_resp_err[0]), 64'd0);
    @(posedge clk);
    @(negedge clk);
    if_resp_ready[0] = 1'b0;

    f_access(0, BASE, 32'hCAFE_F00D, 1'b0, "fetch_lo");
    f_access(0, BASE + 64'h2, 32'h0, 1'b1, "fetch_misalign");

    // Store one word past the end: faults or wraps onto word 0.
    d_access(0, BASE + 64'(DEPTH * 8), 1'b1, 8'hFF, 64'h5555_5555_5555_5555,
             64'h0, FAULT_EN, "st_oor");
    d_access(0, BASE, 1'b0, 8'h00, 64'h0,
             FAULT_EN ? 64'hDEAD_BEEF_CAFE_F00D : 64'h5555_5555_5555_5555, 1'b0, "ld_w0_after_oor");

    // LATENCY=3: rise time, hold with ready low, readies blocked throughout.
    d_access(1, BASE + 64'h8, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, "l3_st");
    @(negedge clk);
    d_req_valid[1] = 1'b1; d_req_addr[1] = BASE + 64'h8; d_req_we[1] = 1'b0;
    #1 check("hold d_req_ready", 64'(d_req_ready[1]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    if_req_valid[1] = 1'b1; if_req_addr[1] = BASE;
    cyc = 1;
    #1;
    while (!d_resp_valid[1] && cyc < 20) begin
      check("busy readies", 64'({d_req_ready[1], if_req_ready[1]}), 64'd0);
      @(negedge clk);
      #1 cyc++;
    end
    check("hold latency", 64'(cyc), 64'd3);
    for (int i = 0; i < 5; i++) begin
      check("hold valid", 64'(d_resp_valid[1]), 64'd1);
      check("hold rdata", d_resp_rdata[1], 64'h0123_4567_89AB_CDEF);
      check("hold readies", 64'({d_req_ready[1], if_req_ready[1]}), 64'd0);
      @(negedge clk);
      #1;
    end
    d_req_valid[1] = 1'b0; if_req_valid[1] = 1'b0; d_resp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_resp_ready[1] = 1'b0;
    #1 check("hold released", 64'(d_resp_valid[1]), 64'd0);

    // Reset while BUSY: pending store discarded, next access completes.
    d_access(1, BASE + 64'h18, 1'b1, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1'b0, "pre_st");
    @(negedge clk);
    d_req_valid[1] = 1'b1; d_req_addr[1] = BASE + 64'h18; d_req_we[1] = 1'b1;
    d_req_wstrb[1] = 8'hFF; d_req_wdata[1] = 64'hAAAA_AAAA_AAAA_AAAA;
    @(posedge clk);
    @(negedge clk);
    d_req_valid[1] = 1'b0; d_resp_ready[1] = 1'b1;
    rst = 1'b1;
    #1 check("rst busy valid", 64'(d_resp_valid[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("post rst no resp", 64'(d_resp_valid[1]), 64'd0);
      @(negedge clk);
    end
    d_resp_ready[1] = 1'b0;
    d_access(1, BASE + 64'h18, 1'b0, 8'h00, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, "ld_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
